// File: rtl/fb_pattern_pkg.sv
// fb_pattern_pkg: shared types and colour constants for the framebuffer test-pattern writer.
package fb_pattern_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, PAUSE} state_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  localparam rgb_t BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };
  localparam rgb_t SQ_RGB = 24'hFF8000;
  localparam rgb_t GRID_RGB = 24'h808080;
endpackage

// File: rtl/fb_pattern_writer_if.sv
// fb_pattern_writer_if: wishbone classic bus between the pattern writer and the intercon.
interface fb_pattern_writer_if;
  logic cyc;
  logic stb;
  logic we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [3:0] sel;
  logic [2:0] cti;
  logic [1:0] bte;
  logic ack;
  modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte, input ack);
  modport slave (input cyc, stb, we, adr, dat_ms, sel, cti, bte, output ack);
endinterface

// File: rtl/fb_pattern_pixel.sv
// fb_pattern_pixel: combinational pixel colour (bars, moving square on top).
// Define FB_PATTERN_GRID_EN to overlay a grey 16-pixel grid beneath the square.
module fb_pattern_pixel
  import fb_pattern_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int SQ = 32
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [2:0]    bar,
  input  logic [XW-1:0] sx,
  input  logic [YW-1:0] sy,
  output rgb_t          rgb
);
  logic in_sq;
  assign in_sq = x >= sx && {1'b0, x} < {1'b0, sx} + (XW+1)'(SQ) &&
                 y >= sy && {1'b0, y} < {1'b0, sy} + (YW+1)'(SQ);
`ifdef FB_PATTERN_GRID_EN
  assign rgb = in_sq ? SQ_RGB :
               ((x & XW'(15)) == '0 || (y & YW'(15)) == '0) ? GRID_RGB : BAR_RGB[bar];
`else
  assign rgb = in_sq ? SQ_RGB : BAR_RGB[bar];
`endif
endmodule

// File: rtl/fb_pattern_writer.sv
// fb_pattern_writer: wishbone classic master painting colour bars plus a bouncing square.
// Colour generation lives in fb_pattern_pixel (optional grid via FB_PATTERN_GRID_EN).
module fb_pattern_writer
  import fb_pattern_pkg::*;
#(
  parameter int          HDISP   = 800,
  parameter int          VDISP   = 480,
  parameter logic [31:0] FB_BASE = 32'h0000_0000,
  parameter int          BURST   = 64,
  parameter int          SQ      = 32
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       enable,
  fb_pattern_writer_if.master        wshb,
  output logic                       frame_done
);
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int BW = $clog2(BURST);
  localparam int PW = $clog2(HDISP / 8 + 1);
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d, sx_q, sx_d, nsx;
  logic [YW-1:0] y_q, y_d, sy_q, sy_d, nsy;
  logic [PW-1:0] bpx_q, bpx_d;
  logic [2:0] bar_q, bar_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [31:0] adr_q, adr_d;
  logic dx_q, dx_d, dy_q, dy_d;
  logic acked, x_last, bar_end, frame_last;
  rgb_t rgb;
  fb_pattern_pixel #(.XW(XW), .YW(YW), .SQ(SQ)) u_pixel (
    .x(x_q), .y(y_q), .bar(bar_q), .sx(sx_q), .sy(sy_q), .rgb(rgb)
  );
  always_comb begin
    acked = state_q == WRITE && wshb.ack;
    x_last = x_q == XW'(HDISP - 1);
    bar_end = bpx_q == PW'(HDISP / 8 - 1);
    frame_last = x_last && y_q == YW'(VDISP - 1);
    nsx = dx_q ? sx_q + XW'(1) : sx_q - XW'(1);
    nsy = dy_q ? sy_q + YW'(1) : sy_q - YW'(1);
    x_d = x_q;
    y_d = y_q;
    bpx_d = bpx_q;
    bar_d = bar_q;
    adr_d = adr_q;
    sx_d = sx_q;
    sy_d = sy_q;
    dx_d = dx_q;
    dy_d = dy_q;
    state_d = state_q != WRITE ? (enable ? WRITE : IDLE) :
              !acked ? WRITE :
              burst_q == BW'(BURST - 1) ? PAUSE :
              enable ? WRITE : IDLE;
    burst_d = state_q == PAUSE ? '0 : acked ? burst_q + BW'(1) : burst_q;
    if (acked) begin
      x_d = x_last ? '0 : x_q + XW'(1);
      y_d = frame_last ? '0 : x_last ? y_q + YW'(1) : y_q;
      bpx_d = (x_last || bar_end) ? '0 : bpx_q + PW'(1);
      bar_d = x_last ? '0 : bar_end ? bar_q + 3'd1 : bar_q;
      adr_d = frame_last ? FB_BASE : adr_q + 32'd4;
    end
    // square steps once per frame, flipping direction on reaching either edge
    if (acked && frame_last) begin
      sx_d = nsx;
      sy_d = nsy;
      dx_d = (nsx == XW'(HDISP - SQ) || nsx == '0) ? ~dx_q : dx_q;
      dy_d = (nsy == YW'(VDISP - SQ) || nsy == '0) ? ~dy_q : dy_q;
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      bpx_q <= '0;
      bar_q <= '0;
      burst_q <= '0;
      adr_q <= FB_BASE;
      sx_q <= '0;
      sy_q <= '0;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      bpx_q <= bpx_d;
      bar_q <= bar_d;
      burst_q <= burst_d;
      adr_q <= adr_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end
  assign wshb.cyc = state_q == WRITE;
  assign wshb.stb = state_q == WRITE;
  assign wshb.we = state_q == WRITE;
  assign wshb.adr = adr_q;
  assign wshb.dat_ms = state_q == WRITE ? {8'h00, rgb} : '0;
  assign wshb.sel = 4'hF;
  assign wshb.cti = 3'b000;
  assign wshb.bte = 2'b00;
  assign frame_done = acked && frame_last;
endmodule

// File: tb/tb_fb_pattern_writer.sv
// tb_fb_pattern_writer: scoreboard bench for fb_pattern_writer on a 16x4 frame, bursts of 8.
module tb_fb_pattern_writer;
  localparam int HD = 16, VD = 4, BU = 8, SQ = 2;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        last;
  } exp_t;
  logic clk = 0, rst_n = 0, en = 0, fd;
  int n_chk = 0, n_err = 0;
  int mx, my, msx, msy, ack_cnt, frame_cnt, stall_cnt;
  bit mdx, mdy;
  logic [31:0] d00, d01, d11, d51;
  exp_t q[$];
  fb_pattern_writer_if wb();
  fb_pattern_writer #(.HDISP(HD), .VDISP(VD), .FB_BASE(BASE), .BURST(BU), .SQ(SQ)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(en), .wshb(wb.master), .frame_done(fd)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask
  function automatic logic [23:0] px(input int x, input int y, input int sx, input int sy);
    if (x >= sx && x < sx + SQ && y >= sy && y < sy + SQ) return 24'hFF8000;
`ifdef FB_PATTERN_GRID_EN
    if (x % 16 == 0 || y % 16 == 0) return 24'h808080;
`endif
    return BARS[x * 8 / HD];
  endfunction
  task automatic push_exp();
    exp_t e;
    e.adr = BASE + 32'(4 * (my * HD + mx));
    e.dat = {8'h00, px(mx, my, msx, msy)};
    e.last = mx == HD - 1 && my == VD - 1;
    q.push_back(e);
  endtask
  task automatic step();
    if (mx == HD - 1 && my == VD - 1) begin
      mx = 0;
      my = 0;
      msx += mdx ? 1 : -1;
      msy += mdy ? 1 : -1;
      if (msx == HD - SQ || msx == 0) mdx = !mdx;
      if (msy == VD - SQ || msy == 0) mdy = !mdy;
    end else begin
      mx++;
      if (mx == HD) begin
        mx = 0;
        my++;
      end
    end
    push_exp();
  endtask
  // every presented word is checked against the head; an acked word retires it
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_eq_stb", wb.cyc, wb.stb);
      if (wb.stb) begin
        if (q.size() == 0) chk("sb_empty", 32'(q.size()), 1);
        else begin
          chk("adr", wb.adr, q[0].adr);
          chk("dat", wb.dat_ms, q[0].dat);
          chk("we_sel_cti_bte", {wb.we, wb.sel, wb.cti, wb.bte}, {1'b1, 4'hF, 3'b000, 2'b00});
          if (wb.ack) begin
            chk("frame_done", fd, q[0].last);
            if (ack_cnt == 64) d00 = wb.dat_ms;
            if (ack_cnt == 80) d01 = wb.dat_ms;
            if (ack_cnt == 81) d11 = wb.dat_ms;
            if (ack_cnt == 85) d51 = wb.dat_ms;
            ack_cnt++;
            if (fd) frame_cnt++;
            void'(q.pop_front());
            step();
          end else stall_cnt++;
        end
      end else chk("fd_idle", fd, 0);
    end
  end
  task automatic do_reset();
    rst_n = 0;
    en = 0;
    wb.ack = 0;
    mx = 0; my = 0; msx = 0; msy = 0; mdx = 1; mdy = 1;
    ack_cnt = 0; frame_cnt = 0; stall_cnt = 0;
    q.delete();
    push_exp();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic run_until(input int n, input int stall_w, input int drop_w);
    int st = 0;
    int g = 0;
    while (ack_cnt < n && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
      wb.ack = !(ack_cnt == stall_w && st < 5);
      if (!wb.ack) st++;
      if (ack_cnt == drop_w) en = 0;
    end
    if (ack_cnt < n) chk("run_timeout", 32'(ack_cnt), 32'(n));
  endtask
  task automatic wait_stb();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!wb.stb && g < 50);
    chk("stb_seen", wb.stb, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    wb.ack = 1;
    chk("rst_dat", wb.dat_ms, 0);
    repeat (20) begin
      @(negedge clk);
      chk("idle_cyc", wb.cyc, 0);
      chk("idle_stb", wb.stb, 0);
      chk("idle_adr", wb.adr, BASE);
      chk("idle_fd", fd, 0);
    end
    do_reset();
    wb.ack = 1;
    en = 1;
    wait_stb();
    repeat (7) begin
      @(negedge clk);
      chk("burst_stb", wb.stb, 1);
    end
    @(negedge clk);
    chk("pause_cyc", wb.cyc, 0);
    @(negedge clk);
    chk("resume_cyc", wb.cyc, 1);
    chk("resume_adr", wb.adr, 32'h120);
    do_reset();
    wb.ack = 1;
    en = 1;
    run_until(4, 3, -1);
    @(negedge clk);
    chk("w4_stb", wb.stb, 1);
    chk("w4_adr", wb.adr, 32'h110);
    chk("stall_cycles", 32'(stall_cnt), 5);
    #2 rst_n = 0;
    #1;
    chk("async_cyc", wb.cyc, 0);
    chk("async_adr", wb.adr, BASE);
    do_reset();
    wb.ack = 1;
    en = 1;
    run_until(86, -1, -1);
    chk("frames", 32'(frame_cnt), 1);
`ifdef FB_PATTERN_GRID_EN
    chk("px00_f2", d00, 32'h00808080);
    chk("px01_f2", d01, 32'h00808080);
`else
    chk("px00_f2", d00, 32'h00FFFFFF);
    chk("px01_f2", d01, 32'h00FFFFFF);
`endif
    chk("px11_f2", d11, 32'h00FF8000);
    chk("px51_f2", d51, 32'h0000FFFF);
    do_reset();
    wb.ack = 1;
    en = 1;
    run_until(6, 5, 5);
    repeat (3) begin
      @(negedge clk);
      chk("drop_cyc", wb.cyc, 0);
    end
    en = 1;
    wait_stb();
    chk("reen_adr", wb.adr, 32'h118);
    run_until(10, -1, -1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
